// File: rtl/max7219_frame_sequencer.sv
// Frame sequencer for a daisy-chained MAX7219 string: boot configuration, digit redraws
// on request and periodic re-initialisation, one 16-bit command per device per frame.
module max7219_frame_sequencer #(
    parameter int          DEVICES        = 2,
    parameter logic [3:0]  INTENSITY      = 4'h7,
    parameter logic [23:0] REFRESH_CYCLES = 24'd1_000_000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DEVICES*64-1:0]  digits_in,
    input  logic                   update,
    output logic [DEVICES*16-1:0]  frame_data,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic                   busy,
    output logic                   init_done
);

    typedef enum logic [1:0] {ST_INIT, ST_DIGITS, ST_IDLE} state_t;

    state_t                  state_reg, state_next;
    logic [2:0]              idx_reg, idx_next;
    logic                    valid_reg, valid_next;
    logic [DEVICES*64-1:0]   next_buf_reg;
    logic [DEVICES*64-1:0]   cur_buf_reg;
    logic                    draw_pend_reg;
    logic                    reinit_pend_reg;
    logic [23:0]             cnt_reg;
    logic                    init_done_reg;

    logic                    xfer;
    logic                    load_cur;
    logic                    enter_init;
    logic                    done_set;
    logic [15:0]             init_word;
    logic [3:0]              digit_num;

    assign xfer = valid_reg & frame_ready;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        valid_next = valid_reg;
        load_cur   = 1'b0;
        enter_init = 1'b0;
        done_set   = 1'b0;
        case (state_reg)
            ST_INIT: begin
                // valid is only low here in the first cycle out of reset
                if (!valid_reg) begin
                    valid_next = 1'b1;
                end else if (xfer) begin
                    if (idx_reg == 3'd4) begin
                        state_next = ST_DIGITS;
                        idx_next   = 3'd0;
                        load_cur   = 1'b1;
                        done_set   = 1'b1;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end
            ST_DIGITS: begin
                if (!valid_reg) begin
                    valid_next = 1'b1;
                end else if (xfer) begin
                    if (idx_reg == 3'd7) begin
                        state_next = ST_IDLE;
                        idx_next   = 3'd0;
                        valid_next = 1'b0;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (reinit_pend_reg) begin
                    state_next = ST_INIT;
                    idx_next   = 3'd0;
                    valid_next = 1'b1;
                    enter_init = 1'b1;
                end else if (draw_pend_reg) begin
                    state_next = ST_DIGITS;
                    idx_next   = 3'd0;
                    valid_next = 1'b1;
                    load_cur   = 1'b1;
                end
            end
            default: begin
                state_next = ST_INIT;
                idx_next   = 3'd0;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= ST_INIT;
            idx_reg         <= 3'd0;
            valid_reg       <= 1'b0;
            next_buf_reg    <= '0;
            cur_buf_reg     <= '0;
            draw_pend_reg   <= 1'b0;
            reinit_pend_reg <= 1'b0;
            cnt_reg         <= 24'd0;
            init_done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            valid_reg <= valid_next;
            if (update) begin
                next_buf_reg <= digits_in;
            end
            if (load_cur) begin
                cur_buf_reg <= next_buf_reg;
            end
            // a request landing in the same cycle as the snapshot stays pending
            if (update) begin
                draw_pend_reg <= 1'b1;
            end else if (load_cur) begin
                draw_pend_reg <= 1'b0;
            end
            if (enter_init) begin
                cnt_reg         <= 24'd0;
                reinit_pend_reg <= 1'b0;
            end else if (cnt_reg == REFRESH_CYCLES - 24'd1) begin
                cnt_reg         <= 24'd0;
                reinit_pend_reg <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 24'd1;
            end
            if (done_set) begin
                init_done_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        init_word = 16'h0000;
        case (idx_reg)
            3'd0:    init_word = 16'h0F00;
            3'd1:    init_word = 16'h0B07;
            3'd2:    init_word = 16'h0900;
            3'd3:    init_word = {12'h0A0, INTENSITY};
            3'd4:    init_word = 16'h0C01;
            default: init_word = 16'h0000;
        endcase
    end

    assign digit_num = {1'b0, idx_reg} + 4'd1;

    genvar gi;
    generate
        for (gi = 0; gi < DEVICES; gi++) begin : g_dev
            logic [63:0] dev_bytes;
            logic [7:0]  seg;
            assign dev_bytes = cur_buf_reg[gi*64 +: 64];
            assign seg       = dev_bytes[{idx_reg, 3'b000} +: 8];
            assign frame_data[gi*16 +: 16] = (state_reg == ST_INIT) ? init_word
                                                                    : {4'h0, digit_num, seg};
        end
    endgenerate

    assign frame_valid = valid_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign init_done   = init_done_reg;

endmodule

// File: tb/tb_max7219_frame_sequencer.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor pops on each transfer.
// A second 1-device instance with a short refresh period checks periodic re-initialisation.
module tb_max7219_frame_sequencer;

    logic         clk;
    logic         reset_n;
    logic [127:0] digits_in;
    logic         update;
    logic [31:0]  frame_data;
    logic         frame_valid;
    logic         frame_ready;
    logic         busy;
    logic         init_done;

    logic [63:0]  digits_r;
    logic         update_r;
    logic [15:0]  frame_data_r;
    logic         frame_valid_r;
    logic         frame_ready_r;
    logic         busy_r;
    logic         init_done_r;

    int n_cmp = 0;
    int n_bad = 0;
    int xfer_total = 0;
    int since_reset = 0;
    int cyc = 0;
    int r_idx = 0;
    int r_last = -1;
    int r_passes = 0;
    logic rnd_ready = 1'b0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] BOOT [13] = '{
        32'h0F000F00, 32'h0B070B07, 32'h09000900, 32'h0A070A07, 32'h0C010C01,
        32'h01000100, 32'h02000200, 32'h03000300, 32'h04000400,
        32'h05000500, 32'h06000600, 32'h07000700, 32'h08000800
    };
    localparam logic [15:0] CFG16 [5] = '{16'h0F00, 16'h0B07, 16'h0900, 16'h0A07, 16'h0C01};

    max7219_frame_sequencer #(
        .DEVICES(2), .INTENSITY(4'h7), .REFRESH_CYCLES(24'd1_000_000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .digits_in(digits_in), .update(update),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .busy(busy), .init_done(init_done)
    );

    max7219_frame_sequencer #(
        .DEVICES(1), .INTENSITY(4'h7), .REFRESH_CYCLES(24'd64)
    ) dut_ref (
        .clk(clk), .reset_n(reset_n), .digits_in(digits_r), .update(update_r),
        .frame_data(frame_data_r), .frame_valid(frame_valid_r), .frame_ready(frame_ready_r),
        .busy(busy_r), .init_done(init_done_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] digit_frame(input logic [127:0] pat, input int k);
        logic [31:0] f;
        f = '0;
        for (int d = 0; d < 2; d++) begin
            f[16*d +: 16] = {4'h0, 4'(k + 1), pat[64*d + 8*k +: 8]};
        end
        return f;
    endfunction

    function automatic logic [127:0] rnd_pat();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic push_digits(input logic [127:0] pat);
        for (int k = 0; k < 8; k++) exp_q.push_back(digit_frame(pat, k));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        frame_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 2 && n < budget) begin
            tick();
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        chk("idle_reached", 64'(quiet >= 2), 1);
        chk("queue_drained", 64'(exp_q.size()), 0);
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int n = 0;
        while (xfer_total < target && n < budget) begin
            tick();
            n++;
        end
        chk("xfer_reached", 64'(xfer_total >= target), 1);
    endtask

    // issued from IDLE: flag set on the first edge, DIGITS valid after the second
    task automatic pulse_update(input logic [127:0] pat);
        update = 1'b1;
        digits_in = pat;
        tick();
        update = 1'b0;
        chk("draw_wait", frame_valid, 0);
        tick();
        chk("draw_start", frame_valid, 1);
    endtask

    // main-instance monitor
    initial begin
        logic        hold_v;
        logic [31:0] hold_data;
        logic [31:0] e;
        hold_v = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                since_reset = 0;
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("hold_valid", frame_valid, 1);
                    chk("hold_data", frame_data, hold_data);
                end
                if (frame_valid && frame_ready) begin
                    chk("init_done_at_xfer", init_done, 64'(since_reset >= 5));
                    chk("frame_expected", 64'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("frame_data", frame_data, e);
                    end
                    $display("xfer %0d: frame_data=%h", xfer_total, frame_data);
                    since_reset++;
                    xfer_total++;
                    hold_v = 1'b0;
                end else if (frame_valid) begin
                    hold_v = 1'b1;
                    hold_data = frame_data;
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    // refresh-instance monitor: endless INIT+blank-digit passes, 64-65 cycles apart
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                r_idx = 0;
                r_last = -1;
            end else if (frame_valid_r) begin
                e = (r_idx < 5) ? CFG16[r_idx] : {8'(r_idx - 4), 8'h00};
                chk("ref_frame", frame_data_r, e);
                chk("ref_busy", busy_r, 1);
                if (r_idx == 0) begin
                    if (r_last >= 0) begin
                        chk("ref_spacing", 64'((cyc - r_last) >= 64 && (cyc - r_last) <= 65), 1);
                    end
                    r_last = cyc;
                    r_passes++;
                end
                r_idx = (r_idx + 1) % 13;
            end
        end
    end

    initial begin
        logic [127:0] pa, pb, pc;
        int base, k, mode;
        reset_n = 1'b0;
        update = 1'b0;
        digits_in = '0;
        frame_ready = 1'b1;
        digits_r = '0;
        update_r = 1'b0;
        frame_ready_r = 1'b1;

        // reset state and boot sequence under random backpressure
        repeat (3) tick();
        chk("reset_valid", frame_valid, 0);
        chk("reset_busy", busy, 1);
        chk("reset_init_done", init_done, 0);
        foreach (BOOT[i]) exp_q.push_back(BOOT[i]);
        rnd_ready = 1'b1;
        reset_n = 1'b1;
        tick();
        chk("first_frame_valid", frame_valid, 1);
        wait_idle(2000);
        chk("boot_init_done", init_done, 1);
        rnd_ready = 1'b0;

        // directed redraw
        pa = '0;
        pa[7:0] = 8'h3F;
        pa[64 + 56 +: 8] = 8'h06;
        exp_q.push_back(32'h0100013F);
        for (int i = 1; i < 7; i++) exp_q.push_back(digit_frame(pa, i));
        exp_q.push_back(32'h08060800);
        pulse_update(pa);
        wait_idle(200);

        // update at DIGITS frame 3: A finishes, one IDLE cycle, then B
        pa = rnd_pat();
        pb = rnd_pat();
        base = xfer_total;
        push_digits(pa);
        pulse_update(pa);
        wait_xfers(base + 3, 100);
        update = 1'b1;
        digits_in = pb;
        push_digits(pb);
        tick();
        update = 1'b0;
        wait_xfers(base + 8, 100);
        chk("idle_gap_low", frame_valid, 0);
        tick();
        chk("idle_gap_next", frame_valid, 1);
        wait_idle(200);

        // randomized mix
        for (int it = 0; it < 25; it++) begin
            rnd_ready = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 3);
            pa = rnd_pat();
            pb = rnd_pat();
            pc = rnd_pat();
            base = xfer_total;
            if (mode == 2) begin
                // back-to-back updates from IDLE: A is snapshotted, B stays pending
                update = 1'b1;
                digits_in = pa;
                tick();
                digits_in = pb;
                chk("dbl_wait", frame_valid, 0);
                tick();
                update = 1'b0;
                chk("dbl_start", frame_valid, 1);
                push_digits(pa);
                push_digits(pb);
            end else begin
                push_digits(pa);
                pulse_update(pa);
                if (mode != 0) begin
                    k = (mode == 1) ? $urandom_range(1, 7) : $urandom_range(1, 5);
                    wait_xfers(base + k, 400);
                    update = 1'b1;
                    digits_in = pb;
                    if (mode == 3) begin
                        tick();
                        digits_in = pc;
                    end
                    tick();
                    update = 1'b0;
                    push_digits((mode == 3) ? pc : pb);
                end
            end
            wait_idle(1000);
        end
        rnd_ready = 1'b0;

        // reset at DIGITS frame 5: restart from INIT with blank digits
        pa = rnd_pat();
        base = xfer_total;
        push_digits(pa);
        pulse_update(pa);
        wait_xfers(base + 5, 100);
        reset_n = 1'b0;
        exp_q.delete();
        foreach (BOOT[i]) exp_q.push_back(BOOT[i]);
        tick();
        reset_n = 1'b1;
        chk("midreset_valid", frame_valid, 0);
        chk("midreset_init_done", init_done, 0);
        chk("midreset_busy", busy, 1);
        wait_idle(200);
        chk("midreset_done", init_done, 1);

        chk("ref_passes", 64'(r_passes >= 3), 1);
        chk("ref_init_done", init_done_r, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
